fpnew_shared_arbiter: RTL and testbench

Sits directly downstream of the per-core FPU demux FPNEW master ports and shares a single FPNEW instance among NB_CORES of them. Round-robin arbitration on the request channel, with the selection locked until the request is granted. An in-order ID FIFO routes each FPNEW response back to the core that issued it. FPNEW is assumed to return responses in issue order.

---
 rtl/fpnew_shared_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fpnew_shared_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_shared_arbiter.sv
// Shares one FPNEW instance among NB_CORES demux ports: round-robin request
// arbitration with lock-until-grant, and an in-order ID FIFO to route responses.
module fpnew_shared_arbiter #(
    parameter int NB_CORES        = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int NB_ARGS         = 3,
    parameter int OPCODE_WIDTH    = 6,
    parameter int DSFLAGS_WIDTH   = 15,
    parameter int USFLAGS_WIDTH   = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [NB_CORES-1:0]                              slv_req_i,
    output logic [NB_CORES-1:0]                              slv_gnt_o,
    input  logic [NB_CORES-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0] slv_operands_i,
    input  logic [NB_CORES-1:0][OPCODE_WIDTH-1:0]            slv_op_i,
    input  logic [NB_CORES-1:0][DSFLAGS_WIDTH-1:0]           slv_flags_i,
    input  logic [NB_CORES-1:0]                              slv_rready_i,
    output logic [NB_CORES-1:0]                              slv_rvalid_o,
    output logic [NB_CORES-1:0][DATA_WIDTH-1:0]              slv_rdata_o,
    output logic [NB_CORES-1:0][USFLAGS_WIDTH-1:0]           slv_rflags_o,
    output logic                                             fpu_req_o,
    input  logic                                             fpu_gnt_i,
    output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]               fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                          fpu_op_o,
    output logic [DSFLAGS_WIDTH-1:0]                         fpu_flags_o,
    output logic                                             fpu_rready_o,
    input  logic                                             fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                            fpu_rdata_i,
    input  logic [USFLAGS_WIDTH-1:0]                         fpu_rflags_i,
    output logic                                             orphan_rsp_o
);

    localparam int ID_W  = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);

    logic [ID_W-1:0]                       rr_ptr_q, rr_ptr_d;
    logic                                  lock_q, lock_d;
    logic [ID_W-1:0]                       locked_id_q, locked_id_d;
    logic [MAX_OUTSTANDING-1:0][ID_W-1:0]  fifo_q, fifo_d;
    logic [PTR_W-1:0]                      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]                        cnt_q, cnt_d;
    logic                                  orphan_q, orphan_d;

    logic [ID_W-1:0] sel;
    logic            sel_valid;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] head_id;
    logic            push;
    logic            pop;
    int              idx;

    assign fifo_full  = (cnt_q == (PTR_W+1)'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head_id    = fifo_q[rd_ptr_q];

    // While locked the selection is frozen; otherwise first requester at/after rr_ptr.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        idx       = 0;
        if (lock_q) begin
            sel       = locked_id_q;
            sel_valid = slv_req_i[locked_id_q];
        end else begin
            for (int i = 0; i < NB_CORES; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NB_CORES) idx = idx - NB_CORES;
                if (!sel_valid && slv_req_i[idx]) begin
                    sel_valid = 1'b1;
                    sel       = ID_W'(idx);
                end
            end
        end
    end

    assign fpu_req_o      = sel_valid & ~fifo_full;
    assign push           = fpu_req_o & fpu_gnt_i;
    assign fpu_operands_o = slv_operands_i[sel];
    assign fpu_op_o       = slv_op_i[sel];
    assign fpu_flags_o    = slv_flags_i[sel];

    always_comb begin
        slv_gnt_o = '0;
        if (fpu_req_o) slv_gnt_o[sel] = fpu_gnt_i;
    end

    // An empty FIFO accepts and drops any response so FPNEW never stalls on it.
    always_comb begin
        slv_rvalid_o = '0;
        fpu_rready_o = 1'b1;
        if (!fifo_empty) begin
            slv_rvalid_o[head_id] = fpu_rvalid_i;
            fpu_rready_o          = slv_rready_i[head_id];
        end
    end

    assign pop          = fpu_rvalid_i & fpu_rready_o & ~fifo_empty;
    assign slv_rdata_o  = {NB_CORES{fpu_rdata_i}};
    assign slv_rflags_o = {NB_CORES{fpu_rflags_i}};
    assign orphan_rsp_o = orphan_q;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        fifo_d      = fifo_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        orphan_d    = orphan_q | (fifo_empty & fpu_rvalid_i);

        if (push) begin
            lock_d           = 1'b0;
            rr_ptr_d         = (sel == ID_W'(NB_CORES - 1)) ? '0 : sel + ID_W'(1);
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end else if (fpu_req_o) begin
            lock_d      = 1'b1;
            locked_id_d = sel;
        end

        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            locked_id_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            orphan_q    <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            orphan_q    <= orphan_d;
        end
    end

    // ID storage is only read through valid pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_fpnew_shared_arbiter.sv
// Bench for fpnew_shared_arbiter: directed vector table followed by randomized
// traffic checked against a queue-based reference model.
module tb_fpnew_shared_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int NA  = 3;
    localparam int OW  = 6;
    localparam int DFW = 15;
    localparam int UFW = 5;
    localparam int MO  = 4;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [N-1:0]                  slv_req_i;
    logic [N-1:0]                  slv_gnt_o;
    logic [N-1:0][NA-1:0][DW-1:0]  slv_operands_i;
    logic [N-1:0][OW-1:0]          slv_op_i;
    logic [N-1:0][DFW-1:0]         slv_flags_i;
    logic [N-1:0]                  slv_rready_i;
    logic [N-1:0]                  slv_rvalid_o;
    logic [N-1:0][DW-1:0]          slv_rdata_o;
    logic [N-1:0][UFW-1:0]         slv_rflags_o;
    logic                          fpu_req_o;
    logic                          fpu_gnt_i;
    logic [NA-1:0][DW-1:0]         fpu_operands_o;
    logic [OW-1:0]                 fpu_op_o;
    logic [DFW-1:0]                fpu_flags_o;
    logic                          fpu_rready_o;
    logic                          fpu_rvalid_i;
    logic [DW-1:0]                 fpu_rdata_i;
    logic [UFW-1:0]                fpu_rflags_i;
    logic                          orphan_rsp_o;

    fpnew_shared_arbiter #(
        .NB_CORES(N), .DATA_WIDTH(DW), .NB_ARGS(NA), .OPCODE_WIDTH(OW),
        .DSFLAGS_WIDTH(DFW), .USFLAGS_WIDTH(UFW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .slv_req_i(slv_req_i), .slv_gnt_o(slv_gnt_o),
        .slv_operands_i(slv_operands_i), .slv_op_i(slv_op_i), .slv_flags_i(slv_flags_i),
        .slv_rready_i(slv_rready_i), .slv_rvalid_o(slv_rvalid_o),
        .slv_rdata_o(slv_rdata_o), .slv_rflags_o(slv_rflags_o),
        .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
        .fpu_rready_o(fpu_rready_o), .fpu_rvalid_i(fpu_rvalid_i),
        .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i),
        .orphan_rsp_o(orphan_rsp_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic        gnt;
        logic        rv;
        logic [3:0]  rdy;
        logic [31:0] rdata;
        logic        efreq;
        logic [3:0]  esgnt;
        int          esel;
        logic [3:0]  esrv;
        logic        erdy;
        logic        eorph;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int  m_rr;
    bit  m_lock;
    int  m_lid;
    int  m_q[$];
    bit  m_orph;

    function automatic void add(input logic r, input logic [3:0] req, input logic g,
                                input logic rv, input logic [3:0] rdy, input logic [31:0] rd,
                                input logic efreq, input logic [3:0] esgnt, input int esel,
                                input logic [3:0] esrv, input logic erdy, input logic eorph);
        vec_t v;
        v.rst_n = r; v.req = req; v.gnt = g; v.rv = rv; v.rdy = rdy; v.rdata = rd;
        v.efreq = efreq; v.esgnt = esgnt; v.esel = esel; v.esrv = esrv;
        v.erdy = erdy; v.eorph = eorph;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic efreq, input logic [N-1:0] esgnt,
                                 input int esel, input logic [N-1:0] esrv, input logic erdy,
                                 input logic eorph);
        logic [N-1:0][DW-1:0]  exp_rd;
        logic [N-1:0][UFW-1:0] exp_rf;
        for (int p = 0; p < N; p++) begin
            exp_rd[p] = fpu_rdata_i;
            exp_rf[p] = fpu_rflags_i;
        end
        chk({tag, ".fpu_req"},    128'(fpu_req_o),    128'(efreq));
        chk({tag, ".slv_gnt"},    128'(slv_gnt_o),    128'(esgnt));
        chk({tag, ".slv_rvalid"}, 128'(slv_rvalid_o), 128'(esrv));
        chk({tag, ".fpu_rready"}, 128'(fpu_rready_o), 128'(erdy));
        chk({tag, ".orphan"},     128'(orphan_rsp_o), 128'(eorph));
        chk({tag, ".rdata_bc"},   128'(slv_rdata_o),  128'(exp_rd));
        chk({tag, ".rflags_bc"},  128'(slv_rflags_o), 128'(exp_rf));
        if (efreq) begin
            chk({tag, ".op"},       128'(fpu_op_o),       128'(slv_op_i[esel]));
            chk({tag, ".flags"},    128'(fpu_flags_o),    128'(slv_flags_i[esel]));
            chk({tag, ".operands"}, 128'(fpu_operands_o), 128'(slv_operands_i[esel]));
        end
    endtask

    task automatic set_ports_fixed();
        for (int p = 0; p < N; p++) begin
            slv_op_i[p]    = OW'(p + 10);
            slv_flags_i[p] = DFW'(16'h0100 + p);
            for (int a = 0; a < NA; a++)
                slv_operands_i[p][a] = 32'hC0DE_0000 | (p << 8) | a;
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_lid = 0; m_orph = 0;
        m_q.delete();
    endtask

    // Model evaluates the outputs for the current inputs, checks, then advances.
    task automatic model_cycle(input string tag);
        int   msel;
        logic efreq;
        logic [N-1:0] esgnt, esrv;
        logic erdy;
        bit   empty;
        msel = -1;
        if (m_lock) begin
            if (slv_req_i[m_lid]) msel = m_lid;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (msel < 0 && slv_req_i[(m_rr + k) % N]) msel = (m_rr + k) % N;
            end
        end
        empty = (m_q.size() == 0);
        efreq = (msel >= 0) && (m_q.size() < MO);
        esgnt = (efreq && fpu_gnt_i) ? N'(1 << msel) : '0;
        esrv  = (!empty && fpu_rvalid_i) ? N'(1 << m_q[0]) : '0;
        erdy  = empty ? 1'b1 : slv_rready_i[m_q[0]];
        check_outputs(tag, efreq, esgnt, (msel < 0) ? 0 : msel, esrv, erdy, m_orph);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (empty && fpu_rvalid_i) m_orph = 1;
            if (!empty && fpu_rvalid_i && erdy) void'(m_q.pop_front());
            if (efreq && fpu_gnt_i) begin
                m_q.push_back(msel);
                m_rr   = (msel + 1) % N;
                m_lock = 0;
            end else if (efreq) begin
                m_lock = 1;
                m_lid  = msel;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; slv_req_i = '0; slv_rready_i = '1; fpu_gnt_i = 1'b0;
        fpu_rvalid_i = 1'b0; fpu_rdata_i = '0; fpu_rflags_i = '0;
        set_ports_fixed();
        repeat (2) @(posedge clk);
        #1;

        // Round robin between ports 0 and 2, fill FIFO, full stall, pop then grant port 3
        add(0,4'b0000,0,0,4'b1111,0,            0,4'b0000,0,4'b0000,1,0);
        add(1,4'b0101,1,0,4'b1111,0,            1,4'b0001,0,4'b0000,1,0);
        add(1,4'b0101,1,0,4'b1111,0,            1,4'b0100,2,4'b0000,1,0);
        add(1,4'b0101,1,0,4'b1111,0,            1,4'b0001,0,4'b0000,1,0);
        add(1,4'b0101,1,0,4'b1111,0,            1,4'b0100,2,4'b0000,1,0);
        add(1,4'b1000,1,0,4'b1111,0,            0,4'b0000,0,4'b0000,1,0);
        add(1,4'b1000,1,1,4'b1111,32'h11,       0,4'b0000,0,4'b0001,1,0);
        add(1,4'b1000,1,0,4'b1111,0,            1,4'b1000,3,4'b0000,1,0);
        // Drain 2,0,2,3 with a two-cycle backpressure stall on port 2
        add(1,4'b0000,0,1,4'b1111,32'h22,       0,4'b0000,0,4'b0100,1,0);
        add(1,4'b0000,0,1,4'b1111,32'h33,       0,4'b0000,0,4'b0001,1,0);
        add(1,4'b0000,0,1,4'b1011,0,            0,4'b0000,0,4'b0100,0,0);
        add(1,4'b0000,0,1,4'b1011,0,            0,4'b0000,0,4'b0100,0,0);
        add(1,4'b0000,0,1,4'b1111,32'h44,       0,4'b0000,0,4'b0100,1,0);
        add(1,4'b0000,0,1,4'b1111,32'h55,       0,4'b0000,0,4'b1000,1,0);
        // Orphan response, sticky until reset
        add(1,4'b0000,0,1,4'b1111,32'h66,       0,4'b0000,0,4'b0000,1,0);
        add(1,4'b0000,0,0,4'b1111,0,            0,4'b0000,0,4'b0000,1,1);
        add(0,4'b0000,0,0,4'b1111,0,            0,4'b0000,0,4'b0000,1,1);
        add(1,4'b0000,0,0,4'b1111,0,            0,4'b0000,0,4'b0000,1,0);
        // Lock on port 1 for 3 cycles, port 0 joins, grant, then rr_ptr=2
        add(1,4'b0010,0,0,4'b1111,0,            1,4'b0000,1,4'b0000,1,0);
        add(1,4'b0010,0,0,4'b1111,0,            1,4'b0000,1,4'b0000,1,0);
        add(1,4'b0010,0,0,4'b1111,0,            1,4'b0000,1,4'b0000,1,0);
        add(1,4'b0011,0,0,4'b1111,0,            1,4'b0000,1,4'b0000,1,0);
        add(1,4'b0011,1,0,4'b1111,0,            1,4'b0010,1,4'b0000,1,0);
        add(1,4'b0111,1,0,4'b1111,0,            1,4'b0100,2,4'b0000,1,0);
        add(1,4'b0000,0,1,4'b1111,0,            0,4'b0000,0,4'b0010,1,0);
        add(1,4'b0000,0,1,4'b1111,0,            0,4'b0000,0,4'b0100,1,0);
        // Issue IDs 3 then 1, responses routed in order
        add(1,4'b1000,1,0,4'b1111,0,            1,4'b1000,3,4'b0000,1,0);
        add(1,4'b0010,1,0,4'b1111,0,            1,4'b0010,1,4'b0000,1,0);
        add(1,4'b0000,0,1,4'b1111,32'hAAAA0001, 0,4'b0000,0,4'b1000,1,0);
        add(1,4'b0000,0,1,4'b1111,32'hAAAA0002, 0,4'b0000,0,4'b0010,1,0);
        // Simultaneous push and pop keeps the count
        add(1,4'b0001,1,0,4'b1111,0,            1,4'b0001,0,4'b0000,1,0);
        add(1,4'b0001,1,1,4'b1111,32'h77,       1,4'b0001,0,4'b0001,1,0);
        add(1,4'b0000,0,1,4'b1111,32'h88,       0,4'b0000,0,4'b0001,1,0);
        add(1,4'b0000,0,1,4'b1111,0,            0,4'b0000,0,4'b0000,1,0);
        add(1,4'b0000,0,0,4'b1111,0,            0,4'b0000,0,4'b0000,1,1);
        // Reset with an ID outstanding turns its response into an orphan
        add(0,4'b0000,0,0,4'b1111,0,            0,4'b0000,0,4'b0000,1,1);
        add(1,4'b0100,1,0,4'b1111,0,            1,4'b0100,2,4'b0000,1,0);
        add(0,4'b0000,0,0,4'b1111,0,            0,4'b0000,0,4'b0000,1,0);
        add(1,4'b0000,0,1,4'b1111,32'h99,       0,4'b0000,0,4'b0000,1,0);
        add(1,4'b0000,0,0,4'b1111,0,            0,4'b0000,0,4'b0000,1,1);

        foreach (vecs[i]) begin
            rst_n        = vecs[i].rst_n;
            slv_req_i    = vecs[i].req;
            fpu_gnt_i    = vecs[i].gnt;
            fpu_rvalid_i = vecs[i].rv;
            slv_rready_i = vecs[i].rdy;
            fpu_rdata_i  = vecs[i].rdata;
            fpu_rflags_i = vecs[i].rdata[UFW-1:0];
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].efreq, vecs[i].esgnt, vecs[i].esel,
                          vecs[i].esrv, vecs[i].erdy, vecs[i].eorph);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model
        rst_n = 1'b0; slv_req_i = '0; fpu_rvalid_i = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n        = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
            slv_req_i    = N'($urandom);
            fpu_gnt_i    = 1'($urandom_range(0, 1));
            fpu_rvalid_i = ($urandom_range(0, 2) != 0);
            slv_rready_i = N'($urandom | $urandom);
            fpu_rdata_i  = $urandom;
            fpu_rflags_i = UFW'($urandom);
            for (int p = 0; p < N; p++) begin
                slv_op_i[p]    = OW'($urandom);
                slv_flags_i[p] = DFW'($urandom);
                for (int a = 0; a < NA; a++) slv_operands_i[p][a] = $urandom;
            end
            @(negedge clk);
            model_cycle($sformatf("rnd%0d", c));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
